// File: rtl/pattern_sequencer.sv
// Pattern sequencer: walks the buffers named in SEQ1/SEQ2 and streams their payload
// bytes from the pattern-buffer bank to a valid/ready output stage.
module pattern_sequencer #(
  parameter int BUFSIZE  = 27,
  parameter int HDRBYTES = 3,
  parameter int NSTEPS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seq1,
  input  logic [7:0] seq2,
  input  logic [7:0] seq_ctrl,
  input  logic [7:0] patternbyte,
  output logic [2:0] bufp,
  output logic [4:0] fieldp,
  output logic [7:0] pat_out,
  output logic       pat_valid,
  input  logic       pat_ready,
  output logic       busy,
  output logic       seq_done,
  output logic [1:0] step,
  output logic [1:0] state_dbg
);

  // Handshake: a byte moves when pat_valid && pat_ready at a rising edge; pat_out
  // and pat_valid are registered and hold while pat_valid && !pat_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [4:0] HDR     = 5'(HDRBYTES);
  localparam logic [4:0] PAYLOAD = 5'(BUFSIZE - HDRBYTES);

  state_t     state, state_nxt;
  logic       run_q;
  logic [7:0] seq1_s, seq1_s_nxt, seq2_s, seq2_s_nxt;
  logic       loop_s, loop_s_nxt;
  logic [4:0] len_s, len_s_nxt;
  logic       aborted, aborted_nxt;
  logic [2:0] bufp_nxt;
  logic [4:0] fieldp_nxt;
  logic [7:0] pat_out_nxt;
  logic       pat_valid_nxt;
  logic [1:0] step_nxt;

  logic       run_rise, capture, step_last;
  logic [4:0] len_eff, last_field;
  logic [3:0] cur_nib, next_nib, first_nib;
  logic       unused_bits;

  assign unused_bits = seq_ctrl[7];

  function automatic logic [3:0] nib_of(input logic [7:0] s1, input logic [7:0] s2,
                                        input logic [1:0] idx);
    case (idx)
      2'd0:    return s1[3:0];
      2'd1:    return s1[7:4];
      2'd2:    return s2[3:0];
      default: return s2[7:4];
    endcase
  endfunction

  assign run_rise   = seq_ctrl[0] && !run_q;
  assign capture    = !pat_valid || pat_ready;
  assign len_eff    = (len_s == 5'd0 || len_s > PAYLOAD) ? PAYLOAD : len_s;
  assign last_field = HDR + len_eff - 5'd1;
  assign cur_nib    = nib_of(seq1_s, seq2_s, step);
  assign next_nib   = nib_of(seq1_s, seq2_s, step + 2'd1);
  assign first_nib  = nib_of(seq1_s, seq2_s, 2'd0);
  assign step_last  = cur_nib[3] || (step == 2'(NSTEPS - 1));
  assign busy       = (state == LOAD) || (state == RUN);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      seq1_s    <= '0;
      seq2_s    <= '0;
      loop_s    <= 1'b0;
      len_s     <= '0;
      aborted   <= 1'b0;
      bufp      <= '0;
      fieldp    <= HDR;
      pat_out   <= '0;
      pat_valid <= 1'b0;
      step      <= '0;
    end else begin
      state     <= state_nxt;
      run_q     <= seq_ctrl[0];
      seq1_s    <= seq1_s_nxt;
      seq2_s    <= seq2_s_nxt;
      loop_s    <= loop_s_nxt;
      len_s     <= len_s_nxt;
      aborted   <= aborted_nxt;
      bufp      <= bufp_nxt;
      fieldp    <= fieldp_nxt;
      pat_out   <= pat_out_nxt;
      pat_valid <= pat_valid_nxt;
      step      <= step_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    seq1_s_nxt    = seq1_s;
    seq2_s_nxt    = seq2_s;
    loop_s_nxt    = loop_s;
    len_s_nxt     = len_s;
    aborted_nxt   = aborted;
    bufp_nxt      = bufp;
    fieldp_nxt    = fieldp;
    pat_out_nxt   = pat_out;
    pat_valid_nxt = pat_valid;
    step_nxt      = step;
    seq_done      = 1'b0;
    case (state)
      IDLE: if (run_rise) state_nxt = LOAD;
      LOAD: begin
        seq1_s_nxt  = seq1;
        seq2_s_nxt  = seq2;
        loop_s_nxt  = seq_ctrl[1];
        len_s_nxt   = seq_ctrl[6:2];
        aborted_nxt = 1'b0;
        step_nxt    = 2'd0;
        bufp_nxt    = seq1[2:0];
        fieldp_nxt  = HDR;
        state_nxt   = RUN;
      end
      RUN: begin
        if (capture) begin
          if (!seq_ctrl[0]) begin
            // Abort: the slot is freed (any held byte was accepted) but not refilled.
            pat_valid_nxt = 1'b0;
            aborted_nxt   = 1'b1;
            state_nxt     = DONE;
          end else begin
            pat_out_nxt   = patternbyte;
            pat_valid_nxt = 1'b1;
            if (fieldp == last_field) begin
              fieldp_nxt = HDR;
              if (!step_last) begin
                step_nxt = step + 2'd1;
                bufp_nxt = next_nib[2:0];
              end else if (loop_s) begin
                step_nxt = 2'd0;
                bufp_nxt = first_nib[2:0];
              end else begin
                state_nxt = DONE;
              end
            end else begin
              fieldp_nxt = fieldp + 5'd1;
            end
          end
        end
      end
      DONE: begin
        if (!pat_valid) begin
          seq_done  = !aborted;
          state_nxt = IDLE;
        end else if (pat_ready) begin
          pat_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
